llc_input_queue: RTL
====================

// Module: llc_input_queue
// PURPOSE
//  Per-channel input queue in front of the LLC input decoder; one instance each for rst_tb, rsp_in, req_in, dma_req_in.
//  Accepts packets from the NoC/testbench side over valid/ready and presents the head packet to the decoder.
//  Drives llc_*_valid_int and the line address the decoder uses for set extraction.
//  Retires the head only when the decoder issues a get strobe (do_get_req, do_get_dma_req, ...).
// PARAMETERS
//  DEPTH   4   entries; power of two, >= 2
//  DATA_W  64  packet payload width, address excluded
//  ADDR_W  28  line address width; matches LINE_ADDR_BITS
// PORTS
//  clk         in   1                  clock
//  rst         in   1                  reset; one clock clk; reset rst is synchronous and active-high
//  in_valid    in   1                  upstream packet valid
//  in_ready    out  1                  queue can accept this cycle
//  in_data     in   DATA_W             upstream payload
//  in_addr     in   ADDR_W             upstream line address
//  valid_int   out  1                  head packet available; feeds llc_*_valid_int
//  head_data   out  DATA_W             head payload
//  head_addr   out  ADDR_W             head line address; feeds *_in_addr
//  get         in   1                  decoder consumes head this cycle
//  flush       in   1                  discard all queued entries
//  count       out  $clog2(DEPTH+1)    current occupancy
//  underflow   out  1                  sticky flag: get seen while valid_int=0
// BEHAVIOUR
//  - Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0. count is a separate register.
//  - push = in_valid & in_ready. pop = get & valid_int.
//  - in_ready = (count != DEPTH) & !rst.
//    - in_ready does not depend on get. A full queue refuses a push even when a pop occurs in the same cycle.
//  - valid_int = (count != 0). head_data and head_addr = mem[rd_ptr]. All three are combinational from registers.
//  - Latency: a packet accepted at edge N is visible on valid_int after edge N; no bypass.
//  - Next count:
//    - push & !pop: count+1
//    - pop & !push: count-1
//    - both or neither: unchanged
//  - Simultaneous push and pop with 0 < count < DEPTH: write at wr_ptr, read at rd_ptr, both pointers advance.
//  - get while valid_int=0: no state change except underflow <= 1. underflow clears only on rst.
//  - flush = 1: wr_ptr, rd_ptr and count <= 0 at the next edge.
//    - flush has priority over a same-cycle push and pop; the pushed packet is dropped.
//    - in_ready is not gated by flush, so the upstream sender sees the drop as an accept.
//  - rst = 1 (synchronous):
//    - ptrs, count, underflow <= 0
//    - in_ready = 0 while rst is high; valid_int = 0 after the edge
//    - storage contents are not reset; head_data and head_addr are don't-care while valid_int=0
//  - rst mid-operation: queued entries are lost; no partial pop is observable.
//  - Decoder stability: head_data and head_addr must remain stable while valid_int=1 and get=0.
//  - Arithmetic: the count width holds DEPTH exactly; no counter wraps.
// CONFIGURATION
//  - LLC_INQ_BYPASS_EN defined: fall-through on an empty queue.
//    - When count==0: valid_int = in_valid, head_data = in_data, head_addr = in_addr.
//    - If get is also high in that cycle: the packet is consumed without being written; ptrs and count are unchanged.
//    - If get is low: the packet is written normally.
//    - underflow is set only when get=1 while count==0 and in_valid=0.
//  - LLC_INQ_BYPASS_EN undefined: 1-cycle latency exactly as described above; the in_* ports never reach outputs combinationally.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> in_ready=0, valid_int=0, count=0, underflow=0; after release, in_ready=1.
//  2. Fill and drain: push addr 0x10..0x13 with get=0 -> count=4, in_ready=0. A 5th push is refused.
//     Then get for 4 cycles -> head_addr 0x10,0x11,0x12,0x13 in order, then valid_int=0.
//  3. Wrap and concurrent access: hold count=2, then push and get together for 6 cycles.
//     -> count stays 2 and order is preserved across the wrap of both pointers.
//  4. Full with get: count=4, in_valid=1, get=1 -> pop only; count=3 and in_ready=1 in the next cycle.
//  5. Flush priority: count=3, flush=1 with push=1 and get=1 -> count=0 and valid_int=0; the pushed addr 0x20 never appears.
//  6. Underflow and bypass:
//     - Empty queue, get=1 -> underflow=1 and sticky until rst.
//     - With LLC_INQ_BYPASS_EN: empty queue, in_valid=1 with addr 0x30 and get=1 in the same cycle
//       -> head_addr=0x30 that cycle, count stays 0, underflow stays 0.

Source files
------------

// File: rtl/llc_input_queue.sv
// rtl/llc_input_queue.sv - LLC per-channel input queue; optional fall-through via LLC_INQ_BYPASS_EN
module llc_input_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       valid_int,
  output logic [DATA_W-1:0]          head_data,
  output logic [ADDR_W-1:0]          head_addr,
  input  logic                       get,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic bypass_take;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  // Readiness only looks at occupancy, so a full queue refuses a push even when the head is popped.
  assign in_ready  = !full && !rst;
  assign count     = count_q;
  assign underflow = underflow_q;

  // Head presentation to the decoder, optionally falling through from the input when empty
  always_comb begin
    valid_int   = !empty;
    head_data   = data_mem_q[rd_ptr_q];
    head_addr   = addr_mem_q[rd_ptr_q];
    bypass_take = 1'b0;
`ifdef LLC_INQ_BYPASS_EN
    if (empty) begin
      valid_int   = in_valid;
      head_data   = in_data;
      head_addr   = in_addr;
      bypass_take = in_valid && get;
    end
`endif
  end

  // A bypassed packet is consumed straight from the input and never occupies a slot.
  assign push = in_valid && in_ready && !bypass_take;
  assign pop  = get && !empty;

  // Next-state for pointers, occupancy and the sticky underflow flag
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (get && !valid_int) begin
      underflow_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Payload storage; contents are left unreset and a flushed push is never written
  always_ff @(posedge clk) begin
    if (!rst && push && !flush) begin
      data_mem_q[wr_ptr_q] <= in_data;
      addr_mem_q[wr_ptr_q] <= in_addr;
    end
  end

endmodule
